// File: rtl/ddr3_axi_rw_check.sv
// ddr3_axi_rw_check: DDR3 AXI traffic generator that writes a seeded pattern over a region, reads it back and checks every beat.
module ddr3_axi_rw_check #(
  parameter int AXI_ADDR_WIDTH = 28,
  parameter int AXI_DATA_WIDTH = 128,
  parameter int BURST_LEN      = 16,
  parameter int NUM_BURSTS     = 64,
  parameter int START_ADDR     = 0
) (
  input  logic                        sys_clk,
  input  logic                        sys_rst_n,
  input  logic                        init_done,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_awaddr,
  output logic [7:0]                  axi_awlen,
  output logic                        axi_awvalid,
  input  logic                        axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] axi_wstrb,
  output logic                        axi_wlast,
  output logic                        axi_wvalid,
  input  logic                        axi_wready,
  output logic [AXI_ADDR_WIDTH-1:0]   axi_araddr,
  output logic [7:0]                  axi_arlen,
  output logic                        axi_arvalid,
  input  logic                        axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   axi_rdata,
  input  logic                        axi_rlast,
  input  logic                        axi_rvalid,
  output logic [15:0]                 err_cnt,
  output logic [15:0]                 pass_cnt,
  output logic                        error,
  output logic [1:0]                  led
);
  localparam int AW = AXI_ADDR_WIDTH;
  localparam int DW = AXI_DATA_WIDTH;
  localparam int BW = NUM_BURSTS > 1 ? $clog2(NUM_BURSTS) : 1;
  localparam logic [7:0]    LAST  = 8'(BURST_LEN - 1);
  localparam logic [AW-1:0] BLA   = AW'(BURST_LEN);
  localparam logic [AW-1:0] ST    = AW'(START_ADDR);
  localparam logic [BW-1:0] LASTB = BW'(NUM_BURSTS - 1);

  typedef enum logic [2:0] {IDLE, WR_AW, WR_D, RD_AR, RD_D, DONE} state_t;

  function automatic logic [DW-1:0] pat(input logic [23:0] a, input logic [7:0] s);
    return {DW/32{s, a}};
  endfunction

  state_t        state;
  logic [BW-1:0] burst;
  logic [7:0]    beat;
  logic [AW-1:0] base, nxt_base;
  logic [23:0]   beat_addr, nxt_addr;
  logic [7:0]    seed;
  logic [16:0]   err_sum;
  logic          d_bad, r_bad, rl_flag, rl_bad, last_burst;

  assign axi_awlen = LAST;
  assign axi_arlen = LAST;
  assign axi_wstrb = '1;

  always_comb begin
    seed       = pass_cnt[7:0];
    beat_addr  = base[23:0] + 24'(beat);
    nxt_addr   = beat_addr + 24'd1;
    last_burst = burst == LASTB;
    nxt_base   = last_burst ? ST : base + BLA;
    rl_bad     = axi_rlast != (beat == LAST);
    err_sum    = {1'b0, err_cnt} + 17'(d_bad) + 17'(r_bad);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state       <= IDLE;
      burst       <= '0;
      beat        <= '0;
      base        <= ST;
      axi_awaddr  <= '0;
      axi_awvalid <= 1'b0;
      axi_wdata   <= '0;
      axi_wlast   <= 1'b0;
      axi_wvalid  <= 1'b0;
      axi_araddr  <= '0;
      axi_arvalid <= 1'b0;
      err_cnt     <= '0;
      pass_cnt    <= '0;
      error       <= 1'b0;
      led         <= 2'b00;
      d_bad       <= 1'b0;
      r_bad       <= 1'b0;
      rl_flag     <= 1'b0;
    end else begin
      d_bad <= 1'b0;
      r_bad <= 1'b0;
      if (d_bad || r_bad) begin
        err_cnt <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        error   <= 1'b1;
      end
      case (state)
        IDLE: if (init_done) begin
          led[0]      <= 1'b1;
          axi_awvalid <= 1'b1;
          axi_awaddr  <= ST;
          state       <= WR_AW;
        end
        WR_AW: if (axi_awready) begin
          axi_awvalid <= 1'b0;
          axi_wvalid  <= 1'b1;
          axi_wdata   <= pat(beat_addr - 24'(beat), seed);
          axi_wlast   <= LAST == 8'd0;
          beat        <= '0;
          state       <= WR_D;
        end
        WR_D: if (axi_wready) begin
          if (axi_wlast) begin
            axi_wvalid  <= 1'b0;
            axi_wlast   <= 1'b0;
            burst       <= last_burst ? '0 : burst + 1'b1;
            base        <= nxt_base;
            axi_awvalid <= !last_burst;
            axi_awaddr  <= nxt_base;
            axi_arvalid <= last_burst;
            axi_araddr  <= nxt_base;
            state       <= last_burst ? RD_AR : WR_AW;
          end else begin
            beat      <= beat + 8'd1;
            axi_wdata <= pat(nxt_addr, seed);
            axi_wlast <= beat + 8'd1 == LAST;
          end
        end
        RD_AR: if (axi_arready) begin
          axi_arvalid <= 1'b0;
          beat        <= '0;
          rl_flag     <= 1'b0;
          state       <= RD_D;
        end
        RD_D: if (axi_rvalid) begin
          // rlast faults are counted once per burst, data faults once per beat
          d_bad   <= axi_rdata != pat(beat_addr, seed);
          r_bad   <= rl_bad && !rl_flag;
          rl_flag <= rl_flag || rl_bad;
          beat    <= beat + 8'd1;
          if (beat == LAST) begin
            burst       <= last_burst ? '0 : burst + 1'b1;
            base        <= nxt_base;
            axi_arvalid <= !last_burst;
            axi_araddr  <= nxt_base;
            state       <= last_burst ? DONE : RD_AR;
          end
        end
        DONE: begin
          pass_cnt    <= pass_cnt + 16'd1;
          led[1]      <= error || d_bad || r_bad || !led[1];
          axi_awvalid <= 1'b1;
          axi_awaddr  <= ST;
          state       <= WR_AW;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ddr3_axi_rw_check.sv
// tb_ddr3_axi_rw_check: randomized AXI slave with a region memory and a pass-level reference model for the traffic checker.
module tb_ddr3_axi_rw_check;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int BL = 4;
  localparam int NB = 2;

  logic          sys_clk = 1'b0, sys_rst_n = 1'b0, init_done = 1'b0;
  logic [AW-1:0] axi_awaddr, axi_araddr;
  logic [7:0]    axi_awlen, axi_arlen;
  logic          axi_awvalid, axi_wlast, axi_wvalid, axi_arvalid;
  logic          axi_awready = 1'b0, axi_wready = 1'b0, axi_arready = 1'b0;
  logic [DW-1:0] axi_wdata;
  logic [DW/8-1:0] axi_wstrb;
  logic [DW-1:0] axi_rdata = '0;
  logic          axi_rlast = 1'b0, axi_rvalid = 1'b0;
  logic [15:0]   err_cnt, pass_cnt;
  logic          error;
  logic [1:0]    led;

  always #5 sys_clk = ~sys_clk;

  ddr3_axi_rw_check #(
    .AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .BURST_LEN(BL), .NUM_BURSTS(NB), .START_ADDR(0)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .init_done(init_done),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
    .axi_wready(axi_wready), .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid),
    .err_cnt(err_cnt), .pass_cnt(pass_cnt), .error(error), .led(led)
  );

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] expect_word(input int a, input int p);
    logic [DW-1:0] w;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = (32'(p & 255) << 24) | (32'(a) & 32'h00FF_FFFF);
    return w;
  endfunction

  // stimulus knobs set by the main sequence
  int stall = 0, corrupt_addr = -1, early_beat = -1;
  bit rnd = 1'b0;

  // reference model state
  logic [DW-1:0] mem [0:BL*NB-1];
  int tb_pass, exp_err, wr_burst, rd_burst, wr_beat, rd_beat, ra, wa;
  bit exp_error, exp_led1, wr_open, rd_open, burst_rl_bad, rbad, rl;
  bit aw_hold, w_hold, ar_hold, w_prev_last;
  logic [AW-1:0] aw_prev, ar_prev;
  logic [DW-1:0] w_prev, rd;

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      tb_pass = 0; exp_err = 0; exp_error = 0; exp_led1 = 0;
      wr_burst = 0; rd_burst = 0; wr_beat = 0; rd_beat = 0;
      wr_open = 0; rd_open = 0; burst_rl_bad = 0;
      aw_hold = 0; w_hold = 0; ar_hold = 0;
      axi_awready = 0; axi_wready = 0; axi_arready = 0;
      axi_rvalid = 0; axi_rlast = 0; axi_rdata = '0;
    end else begin
      if (aw_hold) check("aw_stable", {axi_awvalid, axi_awaddr}, {1'b1, aw_prev});
      if (ar_hold) check("ar_stable", {axi_arvalid, axi_araddr}, {1'b1, ar_prev});
      if (w_hold) begin
        check("wdata_stable", axi_wdata, w_prev);
        check("wlast_stable", {axi_wvalid, axi_wlast}, {1'b1, w_prev_last});
      end
      axi_awready = stall != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
      axi_wready  = stall != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
      axi_arready = stall != 0 ? 1'($urandom_range(0, 1)) : 1'b1;
      axi_rvalid = 0;
      axi_rlast = 0;
      if (rd_open && (stall == 0 || $urandom_range(0, 3) != 0)) begin
        ra = rd_burst*BL + rd_beat;
        rd = mem[ra];
        rbad = (ra == corrupt_addr) || (rnd && $urandom_range(0, 7) == 0);
        rl = (rd_beat == BL-1);
        if ((rd_burst == 0 && rd_beat == early_beat) || (rnd && $urandom_range(0, 9) == 0)) rl = !rl;
        if (rbad) begin
          rd[0] = ~rd[0];
          exp_err++;
          exp_error = 1;
        end
        if (rl != (rd_beat == BL-1)) burst_rl_bad = 1;
        axi_rvalid = 1;
        axi_rdata = rd;
        axi_rlast = rl;
        rd_beat++;
        if (rd_beat == BL) begin
          if (burst_rl_bad) begin
            exp_err++;
            exp_error = 1;
          end
          burst_rl_bad = 0;
          rd_open = 0;
          rd_beat = 0;
          rd_burst++;
          if (rd_burst == NB) begin
            rd_burst = 0;
            exp_led1 = exp_error ? 1'b1 : !exp_led1;
            tb_pass++;
          end
        end
      end
      if (axi_wvalid) check("w_after_aw", wr_open, 1);
      if (axi_wvalid && axi_wready && wr_open) begin
        wa = wr_burst*BL + wr_beat;
        check("wdata", axi_wdata, expect_word(wa, tb_pass));
        check("wlast", axi_wlast, wr_beat == BL-1);
        mem[wa] = axi_wdata;
        wr_beat++;
        if (wr_beat == BL) begin
          wr_open = 0;
          wr_beat = 0;
          wr_burst = (wr_burst + 1) % NB;
        end
      end
      w_hold = axi_wvalid && !axi_wready;
      w_prev = axi_wdata;
      w_prev_last = axi_wlast;
      if (axi_arvalid) check("ar_after_writes", wr_open, 0);
      if (axi_awvalid && axi_awready) begin
        check("awaddr", axi_awaddr, wr_burst*BL);
        check("awlen", axi_awlen, BL-1);
        wr_open = 1;
      end
      if (axi_arvalid && axi_arready) begin
        check("araddr", axi_araddr, rd_burst*BL);
        check("arlen", axi_arlen, BL-1);
        rd_open = 1;
      end
      aw_hold = axi_awvalid && !axi_awready;
      aw_prev = axi_awaddr;
      ar_hold = axi_arvalid && !axi_arready;
      ar_prev = axi_araddr;
    end
  end

  task automatic run_pass(input int s, input int ca, input int eb, input bit r);
    logic [15:0] start;
    int n;
    start = pass_cnt;
    n = 0;
    stall = s; corrupt_addr = ca; early_beat = eb; rnd = r;
    while (pass_cnt == start && n < 3000) begin
      @(negedge sys_clk);
      n++;
    end
    check("pass_done", pass_cnt != start, 1);
    check("pass_cnt", pass_cnt, tb_pass);
    check("err_cnt", err_cnt, exp_err);
    check("error", error, exp_error);
    check("led", led, {exp_led1, 1'b1});
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valids"}, {axi_awvalid, axi_wvalid, axi_wlast, axi_arvalid}, 0);
    check({tag, "_addrs"}, {axi_awaddr, axi_araddr}, 0);
    check({tag, "_wdata"}, axi_wdata, 0);
    check({tag, "_cnts"}, {err_cnt, pass_cnt, error, led}, 0);
  endtask

  initial begin
    int viol, n;
    repeat (3) @(negedge sys_clk);
    check_reset_outputs("rst");
    check("wstrb", axi_wstrb, {(DW/8){1'b1}});
    sys_rst_n = 1;
    viol = 0;
    repeat (1000) begin
      @(negedge sys_clk);
      if (axi_awvalid || axi_wvalid || axi_arvalid) viol++;
    end
    check("idle_no_valid", viol, 0);
    check("idle_led", led, 2'b00);
    init_done = 1;
    run_pass(0, -1, -1, 0);
    check("beat5_data", mem[5], {4{32'h0000_0005}});
    check("pass0_led", led, 2'b11);
    run_pass(0, 6, -1, 0);
    run_pass(1, -1, -1, 0);
    run_pass(0, -1, 2, 0);
    for (int i = 0; i < 4; i++) run_pass(1, -1, -1, 1);
    stall = 0; rnd = 0; corrupt_addr = -1; early_beat = -1;
    n = 0;
    do begin
      @(negedge sys_clk);
      n++;
    end while (!axi_wvalid && n < 500);
    check("wvalid_seen", axi_wvalid, 1);
    #1 sys_rst_n = 0;
    #1 check_reset_outputs("mid_rst");
    repeat (2) @(negedge sys_clk);
    #1 sys_rst_n = 1;
    run_pass(0, -1, -1, 0);
    check("restart_led", led, 2'b11);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
